// File: rtl/window_generator_pkg.sv
// Shared definitions for the window generator and the convolver that
// consumes its 3x3 windows.
package window_generator_pkg;

  // Default pixel width and number of taps in a 3x3 kernel window.
  localparam int NB_DATA     = 8;
  localparam int KERNEL_SIZE = 9;
  localparam int KERNEL_DIM  = 3;

  // Width of a counter/address covering 0..n-1 (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_generator_if.sv
// Pixel-stream input and 3x3 window output of the window generator.
//
// Handshake: both channels use valid/ready. A pixel transfers on a rising
// edge where i_valid and o_ready are both 1; a window transfers on a rising
// edge where o_valid and i_ready are both 1. A producer holds its data and
// valid stable until the transfer happens. o_ready is combinational:
// o_ready = !o_valid || i_ready.
interface window_generator_if #(
  parameter int NB_DATA = window_generator_pkg::NB_DATA
);
  // Upstream pixel stream
  logic [NB_DATA-1:0] i_pixel;
  logic               i_valid;
  logic               i_sof;
  logic               o_ready;
  // Downstream window, row-major, subframe9 is the newest pixel
  logic [NB_DATA-1:0] subframe1;
  logic [NB_DATA-1:0] subframe2;
  logic [NB_DATA-1:0] subframe3;
  logic [NB_DATA-1:0] subframe4;
  logic [NB_DATA-1:0] subframe5;
  logic [NB_DATA-1:0] subframe6;
  logic [NB_DATA-1:0] subframe7;
  logic [NB_DATA-1:0] subframe8;
  logic [NB_DATA-1:0] subframe9;
  logic               o_valid;
  logic               i_ready;

  // Window generator side
  modport slave (
    input  i_pixel, i_valid, i_sof, i_ready,
    output o_ready, o_valid,
    output subframe1, subframe2, subframe3, subframe4, subframe5,
    output subframe6, subframe7, subframe8, subframe9
  );

  // Environment side: pixel source plus window sink
  modport master (
    output i_pixel, i_valid, i_sof, i_ready,
    input  o_ready, o_valid,
    input  subframe1, subframe2, subframe3, subframe4, subframe5,
    input  subframe6, subframe7, subframe8, subframe9
  );
endinterface

// File: rtl/window_generator_line_buffer.sv
// Line buffer: one image line of pixels stored as a circular RAM indexed by
// column. Reading returns the pixel stored one line ago at this column; the
// same enabled edge overwrites it with the new pixel.
module window_generator_line_buffer #(
  parameter int NB_DATA = 8,
  parameter int DEPTH   = 640,
  parameter int ADDR_W  = 10
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [NB_DATA-1:0] data_i,
  output logic [NB_DATA-1:0] data_o
);

  // Contents are not reset: no window reads them before two full lines
  // have been written.
  logic [NB_DATA-1:0] mem_q [DEPTH];

  assign data_o = mem_q[addr_i];

  // Store the incoming pixel only when the stream advances
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[addr_i] <= data_i;
    end
  end

endmodule

// File: rtl/window_generator.sv
// 3x3 sliding-window generator. Accepts a raster pixel stream and emits one
// window per pixel whose row and column are both >= 2 (no border padding).
// Two chained line buffers supply the two lines above the current pixel; two
// column taps supply columns c-2 and c-1.
module window_generator
  import window_generator_pkg::KERNEL_SIZE;
  import window_generator_pkg::idx_width;
#(
  parameter int NB_DATA    = window_generator_pkg::NB_DATA,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              i_clk,
  input  logic              i_reset,
  window_generator_if.slave bus
);

  localparam int COL_W = idx_width(IMG_WIDTH);
  localparam int ROW_W = idx_width(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]   col_q, col_d, col_cur;
  logic [ROW_W-1:0]   row_q, row_d, row_cur;
  logic               valid_q, valid_d;
  logic [NB_DATA-1:0] win_q [KERNEL_SIZE];
  logic [NB_DATA-1:0] win_d [KERNEL_SIZE];
  // Column taps: *_c1 holds column c-1, *_c2 holds column c-2
  logic [NB_DATA-1:0] top_c1_q, mid_c1_q, bot_c1_q;
  logic [NB_DATA-1:0] top_c2_q, mid_c2_q, bot_c2_q;
  logic [NB_DATA-1:0] lb0_rd, lb1_rd;
  logic               accept, consume, load;

  assign bus.o_ready = ~valid_q | bus.i_ready;
  assign accept      = bus.i_valid & bus.o_ready;
  assign consume     = valid_q & bus.i_ready;

  // A start-of-frame pixel is position (0,0) whatever the counters say,
  // which also discards any partial frame in progress.
  assign col_cur = bus.i_sof ? '0 : col_q;
  assign row_cur = bus.i_sof ? '0 : row_q;
  assign load    = accept && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);

  // lb0 holds line r-1; lb1 receives what lb0 held, so it holds line r-2
  window_generator_line_buffer #(
    .NB_DATA (NB_DATA),
    .DEPTH   (IMG_WIDTH),
    .ADDR_W  (COL_W)
  ) u_line_buffer_0 (
    .clk_i  (i_clk),
    .en_i   (accept),
    .addr_i (col_cur),
    .data_i (bus.i_pixel),
    .data_o (lb0_rd)
  );

  window_generator_line_buffer #(
    .NB_DATA (NB_DATA),
    .DEPTH   (IMG_WIDTH),
    .ADDR_W  (COL_W)
  ) u_line_buffer_1 (
    .clk_i  (i_clk),
    .en_i   (accept),
    .addr_i (col_cur),
    .data_i (lb0_rd),
    .data_o (lb1_rd)
  );

  // Raster position of the next pixel, wrapping column then row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  // Output window: load a new one, or drop valid once consumed, else hold
  always_comb begin
    win_d   = win_q;
    valid_d = valid_q;
    if (consume) begin
      valid_d = 1'b0;
    end
    if (load) begin
      win_d[0] = top_c2_q;
      win_d[1] = top_c1_q;
      win_d[2] = lb1_rd;
      win_d[3] = mid_c2_q;
      win_d[4] = mid_c1_q;
      win_d[5] = lb0_rd;
      win_d[6] = bot_c2_q;
      win_d[7] = bot_c1_q;
      win_d[8] = bus.i_pixel;
      valid_d  = 1'b1;
    end
  end

  // Counters and window output register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  // Column taps shift on every accepted pixel; by column 2 of a line they
  // hold only that line's columns, so windows never straddle lines.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      top_c1_q <= '0;
      mid_c1_q <= '0;
      bot_c1_q <= '0;
      top_c2_q <= '0;
      mid_c2_q <= '0;
      bot_c2_q <= '0;
    end else if (accept) begin
      top_c2_q <= top_c1_q;
      mid_c2_q <= mid_c1_q;
      bot_c2_q <= bot_c1_q;
      top_c1_q <= lb1_rd;
      mid_c1_q <= lb0_rd;
      bot_c1_q <= bus.i_pixel;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.subframe1 = win_q[0];
  assign bus.subframe2 = win_q[1];
  assign bus.subframe3 = win_q[2];
  assign bus.subframe4 = win_q[3];
  assign bus.subframe5 = win_q[4];
  assign bus.subframe6 = win_q[5];
  assign bus.subframe7 = win_q[6];
  assign bus.subframe8 = win_q[7];
  assign bus.subframe9 = win_q[8];

endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator on a 4x4 image.
module tb_window_generator;

  localparam int NB = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WW = 9 * NB;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   lat_pending;

  logic [WW-1:0] exp_q[$];
  logic [NB-1:0] trig_q[$];

  window_generator_if #(.NB_DATA(NB)) bus ();

  window_generator #(
    .NB_DATA    (NB),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] dut_win();
    return {bus.subframe1, bus.subframe2, bus.subframe3,
            bus.subframe4, bus.subframe5, bus.subframe6,
            bus.subframe7, bus.subframe8, bus.subframe9};
  endfunction

  // Hand-written window: pixel value tl is the top-left of a 4-wide raster
  function automatic logic [WW-1:0] win_at(input int tl);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w = {w[WW-NB-1:0], 8'(tl + r * W + c)};
    return w;
  endfunction

  // A 4x4 frame starting at value base yields windows with top-left
  // base+0, +1, +4, +5, loaded by pixels base+10, +11, +14, +15.
  task automatic expect_frame(input int base);
    exp_q.push_back(win_at(base + 0));
    exp_q.push_back(win_at(base + 1));
    exp_q.push_back(win_at(base + 4));
    exp_q.push_back(win_at(base + 5));
    trig_q.push_back(8'(base + 10));
    trig_q.push_back(8'(base + 11));
    trig_q.push_back(8'(base + 14));
    trig_q.push_back(8'(base + 15));
  endtask

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the pixel was accepted,
  // leaving i_valid high so consecutive calls stream back to back.
  task automatic send_pixel(input int pix, input bit sof, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 1);
      repeat (n) begin
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.i_valid = 1'b1;
    bus.i_pixel = 8'(pix);
    bus.i_sof   = sof;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", bus.o_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int base, input int count, input bit gaps);
    for (int i = 0; i < count; i++) send_pixel(base + i, i == 0, gaps);
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    check("windows_left", exp_q.size(), 0);
    check("loads_left", trig_q.size(), 0);
  endtask

  // Hold i_ready low until the first window appears, keep it low for five
  // cycles while checking it is frozen, then release.
  task automatic stall_ctl();
    logic [WW-1:0] held;
    int n;
    bus.i_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.o_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stall_seen", bus.o_valid, 1);
    held = dut_win();
    check("stall_first_win", held, win_at(0));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", bus.o_valid, 1);
      check("stall_hold", dut_win(), held);
      check("stall_ready", bus.o_ready, 0);
    end
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (lat_pending) begin
        check("load_latency", bus.o_valid, 1);
        lat_pending = 1'b0;
      end
      if (bus.o_valid && bus.i_ready) begin
        check("window_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("window", dut_win(), exp_q.pop_front());
      end
      if (bus.i_valid && bus.o_ready && trig_q.size() > 0) begin
        if (bus.i_pixel == trig_q[0]) begin
          void'(trig_q.pop_front());
          lat_pending = 1'b1;
        end
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    lat_pending = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_pixel = '0;
    bus.i_sof   = 1'b0;
    bus.i_ready = 1'b1;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", bus.o_valid, 0);
    check("reset_window", dut_win(), 0);
    rst_n = 1'b1;
    #1;
    check("reset_ready", bus.o_ready, 1);
    @(posedge clk); #1;

    // Plain frame, continuous stream
    expect_frame(0);
    send_frame(0, 16, 0);
    drain();

    // Downstream stall on the first window
    expect_frame(0);
    fork
      send_frame(0, 16, 0);
      stall_ctl();
    join
    drain();

    // Random input gaps
    expect_frame(0);
    send_frame(0, 16, 1);
    drain();

    // Partial frame aborted by a new start of frame
    send_frame(0, 7, 0);
    expect_frame(100);
    send_frame(100, 16, 0);
    drain();

    // Reset mid-frame with a window stuck in the output register
    bus.i_ready = 1'b0;
    trig_q.push_back(8'd10);
    send_frame(0, 11, 0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_valid", bus.o_valid, 1);
    check("pre_reset_window", dut_win(), win_at(0));
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", bus.o_valid, 0);
    check("mid_reset_window", dut_win(), 0);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", bus.o_ready, 1);
    expect_frame(0);
    send_frame(0, 16, 0);
    drain();

    // Two frames back to back
    expect_frame(0);
    expect_frame(16);
    for (int i = 0; i < 32; i++) send_pixel(i, (i % 16) == 0, 0);
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
